// File: rtl/addr_rx_wr_pkg.sv
// Shared definitions for the waveform RAM address sequencers (rx write side and
// tx read side): RAM geometry, bank base addresses, FSM state encoding and the
// switch-to-bank decode.
package addr_rx_wr_pkg;

    localparam int ADDR_W      = 10;
    localparam int FRAME_LEN   = 256;
    localparam int TIMEOUT_CYC = 50000;

    localparam int BANK0_BASE  = 0;
    localparam int BANK1_BASE  = 256;
    localparam int BANK2_BASE  = 512;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Priority decode: switch[0] > switch[1] > switch[2].
    // The result is only meaningful when bank_valid() is true.
    function automatic logic [ADDR_W-1:0] bank_base(input logic [2:0] sw);
        logic [ADDR_W-1:0] base;
        base = ADDR_W'(BANK0_BASE);
        if (sw[0])      base = ADDR_W'(BANK0_BASE);
        else if (sw[1]) base = ADDR_W'(BANK1_BASE);
        else if (sw[2]) base = ADDR_W'(BANK2_BASE);
        return base;
    endfunction

    function automatic logic bank_valid(input logic [2:0] sw);
        return |sw;
    endfunction

endpackage

// File: rtl/addr_rx_wr_if.sv
// Byte-receive / RAM-write bus of the rx address sequencer.
//   rx_valid, rx_data : received byte from uart_rx (one-cycle valid pulse)
//   wr_en, wr_addr,
//   wr_data           : RAM write port
//   busy, frame_done,
//   timeout_err       : frame status
// Modports: slave = the sequencer (consumes bytes, drives the RAM port),
//           master = the environment (supplies bytes, observes writes/status).
interface addr_rx_wr_if #(
    parameter int ADDR_W = addr_rx_wr_pkg::ADDR_W
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic              timeout_err;

    modport slave (
        input  rx_valid, rx_data,
        output wr_en, wr_addr, wr_data, busy, frame_done, timeout_err
    );

    modport master (
        output rx_valid, rx_data,
        input  wr_en, wr_addr, wr_data, busy, frame_done, timeout_err
    );
endinterface

// File: rtl/addr_rx_wr_rx_gap_timer.sv
// Inter-byte gap timer. Counts enabled idle cycles since the last clear and
// flags the cycle on which the gap limit is reached.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the gap count (has priority over tick)
//   tick     : one idle cycle elapsed
//   expire   : combinational pulse, tick on the TIMEOUT_CYC-th consecutive idle cycle
module rx_gap_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick && (cnt != LIMIT)) begin
            // Saturate at the limit; the owner leaves RECV and clears us next cycle.
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = tick & ~clear & (cnt == LIMIT);

endmodule

// File: rtl/addr_rx_wr.sv
// Receive-side waveform address sequencer. Writes UART bytes into the 1024x8
// waveform RAM as FRAME_LEN-byte frames, one frame per bank selected by switch.
//   clk, rst : clock, synchronous active-high reset
//   switch   : bank select, sampled on the first byte of a frame only
//   bus      : rx byte input, RAM write port (registered, one cycle after
//              rx_valid) and frame status (busy / frame_done / timeout_err)
//
// state | meaning
// IDLE  | waiting for the first byte of a frame
// RECV  | frame in progress, bytes written at base + offset
module addr_rx_wr #(
    parameter int ADDR_W      = addr_rx_wr_pkg::ADDR_W,
    parameter int FRAME_LEN   = addr_rx_wr_pkg::FRAME_LEN,
    parameter int TIMEOUT_CYC = addr_rx_wr_pkg::TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   switch,
    addr_rx_wr_if.slave  bus
);
    import addr_rx_wr_pkg::*;

    localparam int OFF_W = $clog2(FRAME_LEN);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              to_q, to_d;

    logic              bank_ok;
    logic [ADDR_W-1:0] bank_addr;
    logic              gap_clear, gap_tick, gap_expire;

    assign bank_ok   = bank_valid(switch);
    assign bank_addr = ADDR_W'(bank_base(switch));

    // The gap count only runs inside a frame; any received byte restarts it.
    assign gap_clear = (state_q == IDLE) | bus.rx_valid;
    assign gap_tick  = (state_q == RECV) & ~bus.rx_valid;

    rx_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (gap_clear),
        .tick   (gap_tick),
        .expire (gap_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            off_q   <= off_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        off_d   = off_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        to_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Bytes arriving with no bank selected are dropped.
                if (bus.rx_valid && bank_ok) begin
                    base_d  = bank_addr;
                    wr_en_d = 1'b1;
                    addr_d  = bank_addr;
                    data_d  = bus.rx_data;
                    off_d   = OFF_W'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                // A byte on the gap-limit cycle wins over the timeout.
                if (bus.rx_valid) begin
                    wr_en_d = 1'b1;
                    addr_d  = base_q + ADDR_W'(off_q);
                    data_d  = bus.rx_data;
                    if (off_q == LAST_OFF) begin
                        done_d  = 1'b1;
                        off_d   = '0;
                        state_d = IDLE;
                    end else begin
                        off_d = off_q + OFF_W'(1);
                    end
                end else if (gap_expire) begin
                    to_d    = 1'b1;
                    off_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                off_d   = '0;
            end
        endcase
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data     = data_q;
    assign bus.busy        = (state_q == RECV);
    assign bus.frame_done  = done_q;
    assign bus.timeout_err = to_q;

endmodule
